// File: rtl/pci_initiator.sv
// pci_initiator: PCI burst master driving FRAME/IRDY/CBE/AD for one memory read/write burst at a time.
// Define PCI_INIT_TRDY_TIMEOUT_EN to abort a data phase after TRDY_TIMEOUT wait states.
module pci_initiator #(
  parameter int MAX_LEN = 16,
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int TRDY_TIMEOUT = 16,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  output logic             wr_pop,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             FRAME,
  output logic             IRDY,
  output logic [3:0]       CBE,
  inout  wire  [31:0]      AD,
  input  logic             TRDY,
  input  logic             DEVSEL
);
  localparam int DW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEVSEL_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ABORT, TURN} state_t;
  state_t state, state_n;
  logic wr_q, err_q, dev_seen, accept, xfer, dev_to, trdy_to, ad_oe;
  logic [31:0] addr_q, ad_out;
  logic [LEN_W-1:0] rem, len_c;
  logic [DW-1:0] dcnt;
  assign accept = state == IDLE && req_valid;
  assign xfer = state == DATA && !TRDY && !DEVSEL;
  assign dev_to = state == DATA && !dev_seen && DEVSEL && dcnt == DMAX;
  assign len_c = req_len == '0 ? ONE : req_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : req_len;
  assign AD = ad_oe ? ad_out : 'z;
`ifdef PCI_INIT_TRDY_TIMEOUT_EN
  localparam int WW = $clog2(TRDY_TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(TRDY_TIMEOUT - 1);
  logic [WW-1:0] wcnt;
  assign trdy_to = state == DATA && !DEVSEL && TRDY && wcnt == WMAX;
  always_ff @(posedge CLK) begin
    if (!RST && state == DATA && !DEVSEL && TRDY) wcnt <= wcnt + 1'b1;
    else wcnt <= '0;
  end
`else
  assign trdy_to = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = req_valid ? ADDR : IDLE;
      ADDR:  state_n = DATA;
      DATA:  state_n = (dev_to || trdy_to) ? ABORT : (xfer && rem == ONE) ? TURN : DATA;
      ABORT: state_n = TURN;
      TURN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      rem      <= '0;
      dev_seen <= 1'b0;
      dcnt     <= '0;
    end else begin
      rd_valid <= xfer && !wr_q;
      if (xfer && !wr_q) rd_data <= AD;
      if (xfer) rem <= rem - ONE;
      if (state == DATA && !DEVSEL) dev_seen <= 1'b1;
      if (state == DATA && DEVSEL && !dev_seen) dcnt <= dcnt + 1'b1;
      if (state_n == ABORT) err_q <= 1'b1;
      if (accept) begin
        addr_q   <= req_addr;
        wr_q     <= req_write;
        rem      <= len_c;
        err_q    <= 1'b0;
        dev_seen <= 1'b0;
        dcnt     <= '0;
      end
    end
  end
  // FRAME deasserts for the final data phase so the target sees the burst end
  always_comb begin
    req_ready = state == IDLE && !RST;
    FRAME     = !(state == ADDR || (state == DATA && rem != ONE));
    IRDY      = !(state == DATA || state == ABORT);
    CBE       = state == ADDR ? {3'b011, wr_q} : (state == DATA || state == ABORT) ? 4'b0000 : 4'b1111;
    ad_oe     = state == ADDR || (state == DATA && wr_q);
    ad_out    = state == ADDR ? addr_q : wr_data;
    wr_pop    = xfer && wr_q;
    done      = state == TURN;
    err       = state == TURN && err_q;
  end
endmodule
